// File: rtl/ram_pkg.sv
// Shared memory-block constants: clear-sequencer state encoding
// and read-during-write mode selectors.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int WR_NONE = 0;
  localparam int WR_DATA = 1;

endpackage

// File: rtl/ram_clr_if.sv
// User access bus of ram_clr: request/write/clear inputs and
// read data, read-valid, busy and drop outputs.
interface ram_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  import ram_pkg::*;

  logic              i_req;
  logic              i_write_en;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_write_data;
  logic              i_clear;
  logic [DATA_W-1:0] o_read_data;
  logic              o_read_valid;
  logic              o_busy;
  logic              o_drop;

  modport master (
    output i_req,
    output i_write_en,
    output i_addr,
    output i_write_data,
    output i_clear,
    input  o_read_data,
    input  o_read_valid,
    input  o_busy,
    input  o_drop
  );

  modport slave (
    input  i_req,
    input  i_write_en,
    input  i_addr,
    input  i_write_data,
    input  i_clear,
    output o_read_data,
    output o_read_valid,
    output o_busy,
    output o_drop
  );

endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps clr_addr 0..DEPTH-1 after reset or i_clear.
// Ports: i_clk, i_rst_n, i_clear in; busy, clr_we, clr_addr out.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            st_q;
  state_t            st_d;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] a_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st_q <= ST_CLEAR;
      a_q  <= '0;
    end else begin
      st_q <= st_d;
      a_q  <= a_d;
    end
  end

  always_comb begin
    st_d = st_q;
    a_d  = a_q;
    unique case (st_q)
      ST_CLEAR: begin
        if (i_clear) begin
          a_d = '0;
        end else if (a_q == LAST) begin
          st_d = ST_IDLE;
        end else begin
          a_d = a_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_clear) begin
          st_d = ST_CLEAR;
          a_d  = '0;
        end
      end
    endcase
  end

  assign busy     = (st_q == ST_CLEAR);
  // No sweep write on an edge that samples reset.
  assign clr_we   = busy & i_rst_n;
  assign clr_addr = a_q;

endmodule

// File: rtl/ram_clr.sv
// Single-port RAM, registered read, read-valid, hardware clear.
// Ports: i_clk, i_rst_n (sync, active-low), bus (ram_clr_if.slave).
module ram_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 3,
  parameter int WR_THRU = WR_NONE
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  ram_clr_if.slave bus
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic THRU  = (WR_THRU == WR_DATA);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              acc;
  logic              wr_u;
  logic              rd_u;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  logic [DATA_W-1:0] rd_q;
  logic              vld_q;
  logic              drop_q;

  ram_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (bus.i_clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // i_clear wins over a same-edge request.
  assign acc  = i_rst_n & ~busy
              & ~bus.i_clear & bus.i_req;
  assign wr_u = acc & bus.i_write_en;
  assign rd_u = acc & ~bus.i_write_en;

  // Sweep and user port share one write port.
  assign we = clr_we | wr_u;
  assign wa = clr_we ? clr_addr : bus.i_addr;
  assign wd = clr_we ? '0 : bus.i_write_data;

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_q   <= '0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      vld_q  <= rd_u | (wr_u & THRU);
      drop_q <= bus.i_req & (busy | bus.i_clear);
      if (rd_u) begin
        rd_q <= mem[bus.i_addr];
      end else if (wr_u & THRU) begin
        rd_q <= bus.i_write_data;
      end
    end
  end

  assign bus.o_read_data  = rd_q;
  assign bus.o_read_valid = vld_q;
  assign bus.o_busy       = busy;
  assign bus.o_drop       = drop_q;

endmodule

// File: tb/tb_ram_clr.sv
// Bench for ram_clr: two instances (no write-through / write-through)
// driven identically and compared against a behavioural model.
module tb_ram_clr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       wen;
  logic [2:0] addr;
  logic [3:0] wdata;
  logic       clr;

  int checks = 0;
  int errors = 0;

  ram_clr_if #(.DATA_W(4), .ADDR_W(3)) bus0 ();
  ram_clr_if #(.DATA_W(4), .ADDR_W(3)) bus1 ();

  assign bus0.i_req        = req;
  assign bus0.i_write_en   = wen;
  assign bus0.i_addr       = addr;
  assign bus0.i_write_data = wdata;
  assign bus0.i_clear      = clr;
  assign bus1.i_req        = req;
  assign bus1.i_write_en   = wen;
  assign bus1.i_addr       = addr;
  assign bus1.i_write_data = wdata;
  assign bus1.i_clear      = clr;

  ram_clr #(.DATA_W(4), .ADDR_W(3), .WR_THRU(0)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  ram_clr #(.DATA_W(4), .ADDR_W(3), .WR_THRU(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  // Model: contents, edges of clear still to run, expected outputs.
  logic [3:0] mm [8];
  int         left;
  logic [3:0] er0, er1;
  logic       ev0, ev1, ed;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(logic rn, logic rq, logic w,
                      logic [2:0] a, logic [3:0] d, logic cl);
    rst_n = rn; req = rq; wen = w;
    addr = a; wdata = d; clr = cl;
    @(posedge clk);
    if (!rn) begin
      left = 8; ev0 = 0; ev1 = 0; ed = 0; er0 = 0; er1 = 0;
      for (int i = 0; i < 8; i++) mm[i] = 0;
    end else if (left > 0) begin
      ed = rq; ev0 = 0; ev1 = 0;
      left = cl ? 8 : left - 1;
    end else if (cl) begin
      left = 8; ed = rq; ev0 = 0; ev1 = 0;
      for (int i = 0; i < 8; i++) mm[i] = 0;
    end else begin
      ed = 0;
      if (rq && w) begin
        mm[a] = d; ev0 = 0; ev1 = 1; er1 = d;
      end else if (rq) begin
        er0 = mm[a]; er1 = mm[a]; ev0 = 1; ev1 = 1;
      end else begin
        ev0 = 0; ev1 = 0;
      end
    end
    #1;
    chk("busy0", 8'(bus0.o_busy), 8'(left > 0));
    chk("busy1", 8'(bus1.o_busy), 8'(left > 0));
    chk("drop0", 8'(bus0.o_drop), 8'(ed));
    chk("drop1", 8'(bus1.o_drop), 8'(ed));
    chk("vld0", 8'(bus0.o_read_valid), 8'(ev0));
    chk("vld1", 8'(bus1.o_read_valid), 8'(ev1));
    chk("rd0", 8'(bus0.o_read_data), 8'(er0));
    chk("rd1", 8'(bus1.o_read_data), 8'(er1));
  endtask

  initial begin
    rst_n = 0; req = 0; wen = 0; addr = 0; wdata = 0; clr = 0;
    left = 8; er0 = 0; er1 = 0; ev0 = 0; ev1 = 0; ed = 0;
    for (int i = 0; i < 8; i++) mm[i] = 0;

    // reset, then the 8-edge power-up sweep
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 4'h9, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 3'(i), 0, 0);

    // write then read back; write-through on address 7
    step(1, 1, 1, 3, 4'hA, 0);
    step(1, 1, 0, 3, 0, 0);
    step(1, 1, 1, 7, 4'h5, 0);
    step(1, 1, 0, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // fill, then clear with a colliding write
    for (int i = 0; i < 8; i++) step(1, 1, 1, 3'(i), 4'hF, 0);
    step(1, 1, 1, 0, 4'h1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 3'(i), 0, 0);

    // read during sweep, then reset at clear cycle 5
    step(1, 1, 1, 2, 4'h6, 0);
    step(1, 1, 0, 2, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 2, 0, 0);

    // clear restart while sweeping
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 4'h3, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 79) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
